// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the MDU model:
// busy-timer state encoding and the default MDU latencies.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

endpackage : pipe_ctrl_pkg

// File: rtl/mdu_busy_timer.sv
// MDU occupancy timer: a start strobe loads the mult or div latency, and
// md_busy stays high until the count runs out. It is never aborted early.
module mdu_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_go,
  input  logic e_md_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (md_go) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = e_md_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_BUSY: begin
        // Starts are ignored here, so an illegal start cannot reload the count.
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign md_busy = (state == ST_BUSY);

endmodule : mdu_busy_timer

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler: combines the D-stage hazard, MDU occupancy and
// the CP0 exception request into PC/FD enables and the D/E bubble clear.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_hazard,
  input  logic d_is_md,
  input  logic e_md_start,
  input  logic e_md_div,
  input  logic exc_req,
  output logic pc_en,
  output logic d_en,
  output logic e_clr,
  output logic md_go,
  output logic md_busy,
  output logic stall
);

  // An exception flushes the pipe, so it overrides any stall and blocks new MDU starts.
  assign md_go = e_md_start & ~exc_req & ~md_busy;
  assign stall = ~exc_req & (d_hazard | (d_is_md & (md_busy | e_md_start)));

  assign pc_en = ~stall;
  assign d_en  = ~stall;
  assign e_clr = stall | exc_req;

  mdu_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .md_go    (md_go),
    .e_md_div (e_md_div),
    .md_busy  (md_busy)
  );

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and random stimulus for pipe_stall_ctrl, checked against a
// remaining-busy-cycles reference model.
module tb_pipe_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset, d_hazard, d_is_md, e_md_start, e_md_div, exc_req;
  logic pc_en, d_en, e_clr, md_go, md_busy, stall;

  int total = 0;
  int bad   = 0;
  int busy_left = 0;   // reference model: MDU cycles still outstanding
  int n_busy, n_stall;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_hazard   (d_hazard),
    .d_is_md    (d_is_md),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .exc_req    (exc_req),
    .pc_en      (pc_en),
    .d_en       (d_en),
    .e_clr      (e_clr),
    .md_go      (md_go),
    .md_busy    (md_busy),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_busy, exp_stall, exp_go;
    exp_busy  = (busy_left > 0);
    exp_stall = !exc_req && (d_hazard || (d_is_md && (exp_busy || e_md_start)));
    exp_go    = e_md_start && !exc_req && !exp_busy;
    check({tag, ".md_busy"}, md_busy, exp_busy);
    check({tag, ".stall"},   stall,   exp_stall);
    check({tag, ".pc_en"},   pc_en,   !exp_stall);
    check({tag, ".d_en"},    d_en,    !exp_stall);
    check({tag, ".e_clr"},   e_clr,   exp_stall || exc_req);
    check({tag, ".md_go"},   md_go,   exp_go);
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic tick(input string tag);
    @(negedge clk);
    check_outputs(tag);
    if (md_busy) n_busy++;
    if (stall)   n_stall++;
    @(posedge clk);
    if (!reset)             busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (e_md_start && !exc_req) busy_left = e_md_div ? DIV_N : MULT_N;
    #1;
  endtask

  task automatic idle_inputs();
    d_hazard = 0; d_is_md = 0; e_md_start = 0; e_md_div = 0; exc_req = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset, then release with all inputs low.
    tick("rst");
    tick("rst");
    reset = 1'b1;
    tick("idle");
    check("idle.pc_en", pc_en, 1'b1);
    check("idle.e_clr", e_clr, 1'b0);

    // Mult start followed by an MDU instruction held in D.
    n_busy = 0; n_stall = 0;
    e_md_start = 1; e_md_div = 0; d_is_md = 1;
    tick("mult.start");
    e_md_start = 0;
    for (int i = 0; i < 8; i++) tick("mult.wait");
    check_int("mult.busy_cycles", n_busy, MULT_N);
    check_int("mult.stall_cycles", n_stall, MULT_N + 1);
    idle_inputs();
    tick("mult.done");

    // Div start with an exception at busy cycle 3; timer still runs to completion.
    n_busy = 0;
    e_md_start = 1; e_md_div = 1; d_is_md = 1;
    tick("div.start");
    e_md_start = 0;
    tick("div.b1");
    tick("div.b2");
    exc_req = 1;
    #1;
    check("div.exc.stall", stall, 1'b0);
    check("div.exc.e_clr", e_clr, 1'b1);
    check("div.exc.busy", md_busy, 1'b1);
    tick("div.b3");
    exc_req = 0;
    for (int i = 0; i < 10; i++) tick("div.wait");
    check_int("div.busy_cycles", n_busy, DIV_N);
    idle_inputs();

    // Start and exception together: no MDU start issued.
    e_md_start = 1; e_md_div = 1; exc_req = 1;
    #1;
    check("startexc.md_go", md_go, 1'b0);
    tick("startexc");
    idle_inputs();
    tick("startexc.after");
    check("startexc.busy", md_busy, 1'b0);

    // Single-cycle hazard with the MDU idle.
    d_hazard = 1;
    #1;
    check("haz.stall", stall, 1'b1);
    check("haz.d_en", d_en, 1'b0);
    tick("haz");
    d_hazard = 0;
    tick("haz.after");
    check("haz.after.stall", stall, 1'b0);

    // Asynchronous reset at busy cycle 4 of a div.
    e_md_start = 1; e_md_div = 1;
    tick("rdiv.start");
    e_md_start = 0;
    for (int i = 0; i < 3; i++) tick("rdiv.busy");
    #2;
    reset = 1'b0;
    busy_left = 0;
    #1;
    check("rdiv.async_busy", md_busy, 1'b0);
    tick("rdiv.in_reset");
    reset = 1'b1;
    n_busy = 0;
    e_md_start = 1; e_md_div = 0;
    tick("rdiv.restart");
    e_md_start = 0;
    for (int i = 0; i < 7; i++) tick("rdiv.mult");
    check_int("rdiv.mult_cycles", n_busy, MULT_N);

    // Random traffic, including illegal starts while busy.
    for (int i = 0; i < 400; i++) begin
      d_hazard   = ($urandom_range(0, 7) == 0);
      d_is_md    = ($urandom_range(0, 2) == 0);
      e_md_start = ($urandom_range(0, 5) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      exc_req    = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
